// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//
// Shares the single command port of an SDRAM controller between two
// requesters (port 0 and port 1). One requester is chosen per accepted
// command, round-robin by default. A port may hold its grant for a bounded
// run of back-to-back commands by raising its lock input.
//
// Every accepted read records its issuing port in an in-order tag FIFO. Each
// read word returned by the controller is steered to the port at the FIFO
// head. Both the command path and the read-data path are purely
// combinational, so the arbiter adds no latency.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   pN_cmd_ready_o                 port N command accepted this edge if triggered
//   pN_cmd_trigger_i               port N requests a command
//   pN_cmd_write_i                 1 = write, 0 = read
//   pN_cmd_addr_i                  word address
//   pN_cmd_write_data_i            write data
//   pN_lock_i                      keep the grant for the next command
//   pN_cmd_read_data_o             shared controller read-data bus
//   pN_cmd_read_data_valid_o       read word belongs to port N this cycle
//   ctl_cmd_*                      muxed command to / read return from controller
//   err_o                          sticky: read data arrived with no read outstanding
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
  parameter int unsigned AddrWidth     = 23,
  parameter int unsigned ReadFifoDepth = 8,
  parameter int unsigned LockMax       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  output logic                 p0_cmd_ready_o,
  input  logic                 p0_cmd_trigger_i,
  input  logic                 p0_cmd_write_i,
  input  logic [AddrWidth-1:0] p0_cmd_addr_i,
  input  logic [15:0]          p0_cmd_write_data_i,
  input  logic                 p0_lock_i,
  output logic [15:0]          p0_cmd_read_data_o,
  output logic                 p0_cmd_read_data_valid_o,

  output logic                 p1_cmd_ready_o,
  input  logic                 p1_cmd_trigger_i,
  input  logic                 p1_cmd_write_i,
  input  logic [AddrWidth-1:0] p1_cmd_addr_i,
  input  logic [15:0]          p1_cmd_write_data_i,
  input  logic                 p1_lock_i,
  output logic [15:0]          p1_cmd_read_data_o,
  output logic                 p1_cmd_read_data_valid_o,

  input  logic                 ctl_cmd_ready_i,
  output logic                 ctl_cmd_trigger_o,
  output logic                 ctl_cmd_write_o,
  output logic [AddrWidth-1:0] ctl_cmd_addr_o,
  output logic [15:0]          ctl_cmd_write_data_o,
  input  logic [15:0]          ctl_cmd_read_data_i,
  input  logic                 ctl_cmd_read_data_valid_i,

  output logic                 err_o
);

  localparam int unsigned PtrW  = $clog2(ReadFifoDepth);
  localparam int unsigned CntW  = $clog2(ReadFifoDepth + 1);
  localparam int unsigned LockW = $clog2(LockMax + 1);

  // Registered state
  logic             prio_q, prio_d;
  logic             lock_active_q, lock_active_d;
  logic             lock_owner_q, lock_owner_d;
  logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             err_q, err_d;
  logic             tag_mem_q [ReadFifoDepth];

  // Combinational signals
  logic fifo_full, fifo_empty;
  logic elig0, elig1;
  logic sel, sel_elig, sel_write, sel_lock, owner_lock;
  logic accept, push, pop, head;

  assign fifo_full  = (count_q == CntW'(ReadFifoDepth));
  assign fifo_empty = (count_q == '0);

  // Full check uses the registered count: a same-edge pop does not unblock a read.
  assign elig0 = p0_cmd_trigger_i && !(!p0_cmd_write_i && fifo_full);
  assign elig1 = p1_cmd_trigger_i && !(!p1_cmd_write_i && fifo_full);

  always_comb begin
    sel = prio_q;
    if (lock_active_q) begin
      sel = lock_owner_q;
    end else if (elig0 && !elig1) begin
      sel = 1'b0;
    end else if (elig1 && !elig0) begin
      sel = 1'b1;
    end
  end

  assign sel_elig   = sel ? elig1 : elig0;
  assign sel_write  = sel ? p1_cmd_write_i : p0_cmd_write_i;
  assign sel_lock   = sel ? p1_lock_i : p0_lock_i;
  assign owner_lock = lock_owner_q ? p1_lock_i : p0_lock_i;

  // Handshakes are held low while reset is asserted so nothing is offered
  // to either side during reset.
  assign ctl_cmd_trigger_o    = sel_elig && rst_ni;
  assign ctl_cmd_write_o      = sel_write;
  assign ctl_cmd_addr_o       = sel ? p1_cmd_addr_i : p0_cmd_addr_i;
  assign ctl_cmd_write_data_o = sel ? p1_cmd_write_data_i : p0_cmd_write_data_i;

  assign p0_cmd_ready_o = ctl_cmd_ready_i && !sel && elig0 && rst_ni;
  assign p1_cmd_ready_o = ctl_cmd_ready_i &&  sel && elig1 && rst_ni;

  assign accept = ctl_cmd_trigger_o && ctl_cmd_ready_i;
  assign push   = accept && !sel_write;
  assign pop    = ctl_cmd_read_data_valid_i && !fifo_empty && rst_ni;
  assign head   = tag_mem_q[rd_ptr_q];

  assign p0_cmd_read_data_o       = ctl_cmd_read_data_i;
  assign p1_cmd_read_data_o       = ctl_cmd_read_data_i;
  assign p0_cmd_read_data_valid_o = pop && !head;
  assign p1_cmd_read_data_valid_o = pop &&  head;
  assign err_o                    = err_q;

  // Next-state logic
  always_comb begin
    prio_d        = prio_q;
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    lock_cnt_d    = lock_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    err_d         = err_q;

    if (accept) begin
      prio_d = ~sel;
      // lock_cnt counts accepts already made under the current lock run.
      if (sel_lock && ((32'(lock_cnt_q) + 32'd1) < LockMax)) begin
        lock_active_d = 1'b1;
        lock_owner_d  = sel;
        lock_cnt_d    = lock_cnt_q + 1'b1;
      end else begin
        lock_active_d = 1'b0;
        lock_cnt_d    = '0;
      end
    end else if (lock_active_q && !owner_lock) begin
      lock_active_d = 1'b0;
      lock_cnt_d    = '0;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    if (ctl_cmd_read_data_valid_i && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q        <= 1'b0;
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
      lock_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      prio_q        <= prio_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      lock_cnt_q    <= lock_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      err_q         <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
module tb_sdram_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        p0_cmd_ready_o, p1_cmd_ready_o;
  logic        p0_cmd_trigger_i, p1_cmd_trigger_i;
  logic        p0_cmd_write_i, p1_cmd_write_i;
  logic [22:0] p0_cmd_addr_i, p1_cmd_addr_i;
  logic [15:0] p0_cmd_write_data_i, p1_cmd_write_data_i;
  logic        p0_lock_i, p1_lock_i;
  logic [15:0] p0_cmd_read_data_o, p1_cmd_read_data_o;
  logic        p0_cmd_read_data_valid_o, p1_cmd_read_data_valid_o;
  logic        ctl_cmd_ready_i;
  logic        ctl_cmd_trigger_o, ctl_cmd_write_o;
  logic [22:0] ctl_cmd_addr_o;
  logic [15:0] ctl_cmd_write_data_o;
  logic [15:0] ctl_cmd_read_data_i;
  logic        ctl_cmd_read_data_valid_i;
  logic        err_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk_i = ~clk_i;

  sdram_port_arbiter #(
    .AddrWidth(23), .ReadFifoDepth(8), .LockMax(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .p0_cmd_ready_o(p0_cmd_ready_o), .p0_cmd_trigger_i(p0_cmd_trigger_i),
    .p0_cmd_write_i(p0_cmd_write_i), .p0_cmd_addr_i(p0_cmd_addr_i),
    .p0_cmd_write_data_i(p0_cmd_write_data_i), .p0_lock_i(p0_lock_i),
    .p0_cmd_read_data_o(p0_cmd_read_data_o), .p0_cmd_read_data_valid_o(p0_cmd_read_data_valid_o),
    .p1_cmd_ready_o(p1_cmd_ready_o), .p1_cmd_trigger_i(p1_cmd_trigger_i),
    .p1_cmd_write_i(p1_cmd_write_i), .p1_cmd_addr_i(p1_cmd_addr_i),
    .p1_cmd_write_data_i(p1_cmd_write_data_i), .p1_lock_i(p1_lock_i),
    .p1_cmd_read_data_o(p1_cmd_read_data_o), .p1_cmd_read_data_valid_o(p1_cmd_read_data_valid_o),
    .ctl_cmd_ready_i(ctl_cmd_ready_i), .ctl_cmd_trigger_o(ctl_cmd_trigger_o),
    .ctl_cmd_write_o(ctl_cmd_write_o), .ctl_cmd_addr_o(ctl_cmd_addr_o),
    .ctl_cmd_write_data_o(ctl_cmd_write_data_o), .ctl_cmd_read_data_i(ctl_cmd_read_data_i),
    .ctl_cmd_read_data_valid_i(ctl_cmd_read_data_valid_i), .err_o(err_o)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    p0_cmd_trigger_i = 1'b1; p0_cmd_write_i = 1'b1; p0_cmd_addr_i = 23'h000100;
    p1_cmd_trigger_i = 1'b1; p1_cmd_write_i = 1'b1; p1_cmd_addr_i = 23'h000200;
    ctl_cmd_ready_i = 1'b1;
    repeat (2) tick();
    #1;
    total_cnt++; if (p0_cmd_ready_o !== 1'b0) $display("FAIL reset_p0_ready got %b want 0", p0_cmd_ready_o); else pass_cnt++;
    total_cnt++; if (p1_cmd_ready_o !== 1'b0) $display("FAIL reset_p1_ready got %b want 0", p1_cmd_ready_o); else pass_cnt++;
    total_cnt++; if (ctl_cmd_trigger_o !== 1'b0) $display("FAIL reset_ctl_trigger got %b want 0", ctl_cmd_trigger_o); else pass_cnt++;
    total_cnt++; if (err_o !== 1'b0) $display("FAIL reset_err got %b want 0", err_o); else pass_cnt++;
    total_cnt++; if (ctl_cmd_addr_o !== 23'h000100) $display("FAIL reset_addr_mux got %h want 000100", ctl_cmd_addr_o); else pass_cnt++;
    rst_ni = 1'b1;
    #1;
    total_cnt++; if (p0_cmd_ready_o !== 1'b1 || p1_cmd_ready_o !== 1'b0)
      $display("FAIL first_grant got p0=%b p1=%b want p0=1 p1=0", p0_cmd_ready_o, p1_cmd_ready_o); else pass_cnt++;
    total_cnt++; if (ctl_cmd_trigger_o !== 1'b1) $display("FAIL first_trigger got %b want 1", ctl_cmd_trigger_o); else pass_cnt++;
    $display("reset: released, p0 offered first");
  endtask

  task automatic test_contention();
    for (int i = 0; i < 6; i++) begin
      logic        exp_port;
      logic [22:0] exp_addr;
      logic [15:0] exp_data;
      p0_cmd_addr_i = 23'h000100 + 23'(i); p0_cmd_write_data_i = 16'h1000 + 16'(i);
      p1_cmd_addr_i = 23'h000200 + 23'(i); p1_cmd_write_data_i = 16'h2000 + 16'(i);
      #1;
      exp_port = 1'(i % 2);
      exp_addr = exp_port ? p1_cmd_addr_i : p0_cmd_addr_i;
      exp_data = exp_port ? p1_cmd_write_data_i : p0_cmd_write_data_i;
      total_cnt++; if (p0_cmd_ready_o !== !exp_port || p1_cmd_ready_o !== exp_port)
        $display("FAIL contention_grant[%0d] got p0=%b p1=%b want port %0d", i, p0_cmd_ready_o, p1_cmd_ready_o, exp_port); else pass_cnt++;
      total_cnt++; if (ctl_cmd_addr_o !== exp_addr || ctl_cmd_write_data_o !== exp_data)
        $display("FAIL contention_cmd[%0d] got addr=%h data=%h want addr=%h data=%h", i, ctl_cmd_addr_o, ctl_cmd_write_data_o, exp_addr, exp_data); else pass_cnt++;
      $display("contention: accept %0d by port %0d addr %h", i, exp_port, exp_addr);
      tick();
    end
    p0_cmd_trigger_i = 1'b0; p1_cmd_trigger_i = 1'b0;
  endtask

  task automatic test_read_routing();
    logic [15:0] rdata [3];
    logic        rport [3];
    rdata[0] = 16'hAAAA; rdata[1] = 16'hBBBB; rdata[2] = 16'hCCCC;
    rport[0] = 1'b0;     rport[1] = 1'b1;     rport[2] = 1'b0;
    // Three reads issued one at a time, p0, p1, p0.
    for (int i = 0; i < 3; i++) begin
      p0_cmd_trigger_i = !rport[i]; p0_cmd_write_i = 1'b0;
      p1_cmd_trigger_i =  rport[i]; p1_cmd_write_i = 1'b0;
      p0_cmd_addr_i = 23'h000010 * 23'(i + 1);
      p1_cmd_addr_i = 23'h000010 * 23'(i + 1);
      #1;
      total_cnt++; if ((rport[i] ? p1_cmd_ready_o : p0_cmd_ready_o) !== 1'b1 || ctl_cmd_write_o !== 1'b0)
        $display("FAIL read_issue[%0d] got ready=%b write=%b want ready=1 write=0", i,
                 rport[i] ? p1_cmd_ready_o : p0_cmd_ready_o, ctl_cmd_write_o); else pass_cnt++;
      total_cnt++; if (ctl_cmd_addr_o !== 23'h000010 * 23'(i + 1))
        $display("FAIL read_addr[%0d] got %h want %h", i, ctl_cmd_addr_o, 23'h000010 * 23'(i + 1)); else pass_cnt++;
      tick();
    end
    p0_cmd_trigger_i = 1'b0; p1_cmd_trigger_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ctl_cmd_read_data_valid_i = 1'b1; ctl_cmd_read_data_i = rdata[i];
      #1;
      total_cnt++; if (p0_cmd_read_data_valid_o !== !rport[i] || p1_cmd_read_data_valid_o !== rport[i])
        $display("FAIL read_route[%0d] got v0=%b v1=%b want port %0d", i, p0_cmd_read_data_valid_o, p1_cmd_read_data_valid_o, rport[i]); else pass_cnt++;
      total_cnt++; if ((rport[i] ? p1_cmd_read_data_o : p0_cmd_read_data_o) !== rdata[i])
        $display("FAIL read_data[%0d] got %h want %h", i, rport[i] ? p1_cmd_read_data_o : p0_cmd_read_data_o, rdata[i]); else pass_cnt++;
      $display("read_routing: return %h to port %0d", rdata[i], rport[i]);
      tick();
    end
    ctl_cmd_read_data_valid_i = 1'b0;
    #1;
    total_cnt++; if (err_o !== 1'b0) $display("FAIL read_routing_err got %b want 0", err_o); else pass_cnt++;
  endtask

  task automatic test_fifo_full();
    p0_cmd_trigger_i = 1'b1; p0_cmd_write_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p0_cmd_addr_i = 23'h000300 + 23'(i);
      #1;
      total_cnt++; if (p0_cmd_ready_o !== 1'b1) $display("FAIL fill_ready[%0d] got %b want 1", i, p0_cmd_ready_o); else pass_cnt++;
      tick();
    end
    // Ninth read is blocked while a p1 write still goes through.
    p1_cmd_trigger_i = 1'b1; p1_cmd_write_i = 1'b1; p1_cmd_addr_i = 23'h000400;
    #1;
    total_cnt++; if (p0_cmd_ready_o !== 1'b0) $display("FAIL full_read_blocked got %b want 0", p0_cmd_ready_o); else pass_cnt++;
    total_cnt++; if (p1_cmd_ready_o !== 1'b1 || ctl_cmd_addr_o !== 23'h000400 || ctl_cmd_write_o !== 1'b1)
      $display("FAIL full_write_pass got ready=%b addr=%h write=%b want 1/000400/1", p1_cmd_ready_o, ctl_cmd_addr_o, ctl_cmd_write_o); else pass_cnt++;
    $display("fifo_full: read blocked, p1 write accepted");
    tick();
    p1_cmd_trigger_i = 1'b0;
    // One return: still blocked this cycle, accepted the next.
    ctl_cmd_read_data_valid_i = 1'b1; ctl_cmd_read_data_i = 16'h1234;
    #1;
    total_cnt++; if (p0_cmd_read_data_valid_o !== 1'b1) $display("FAIL full_pop_valid got %b want 1", p0_cmd_read_data_valid_o); else pass_cnt++;
    total_cnt++; if (p0_cmd_ready_o !== 1'b0) $display("FAIL full_same_edge_pop got %b want 0", p0_cmd_ready_o); else pass_cnt++;
    tick();
    ctl_cmd_read_data_valid_i = 1'b0;
    #1;
    total_cnt++; if (p0_cmd_ready_o !== 1'b1) $display("FAIL after_pop_ready got %b want 1", p0_cmd_ready_o); else pass_cnt++;
    $display("fifo_full: read accepted after one return");
    tick();
    p0_cmd_trigger_i = 1'b0;
    // Drain the eight outstanding p0 reads.
    ctl_cmd_read_data_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ctl_cmd_read_data_i = 16'h5000 + 16'(i);
      #1;
      total_cnt++; if (p0_cmd_read_data_valid_o !== 1'b1 || p1_cmd_read_data_valid_o !== 1'b0)
        $display("FAIL drain[%0d] got v0=%b v1=%b want 1/0", i, p0_cmd_read_data_valid_o, p1_cmd_read_data_valid_o); else pass_cnt++;
      tick();
    end
    ctl_cmd_read_data_valid_i = 1'b0;
    #1;
    total_cnt++; if (err_o !== 1'b0) $display("FAIL drain_err got %b want 0", err_o); else pass_cnt++;
  endtask

  task automatic test_lock();
    // prio is 1 here (last accept was by p0).
    p0_cmd_trigger_i = 1'b1; p0_cmd_write_i = 1'b1; p0_cmd_addr_i = 23'h000600;
    p1_cmd_trigger_i = 1'b1; p1_cmd_write_i = 1'b1; p1_cmd_addr_i = 23'h000500; p1_lock_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      total_cnt++; if (p1_cmd_ready_o !== 1'b1 || p0_cmd_ready_o !== 1'b0)
        $display("FAIL lock_run[%0d] got p0=%b p1=%b want p0=0 p1=1", i, p0_cmd_ready_o, p1_cmd_ready_o); else pass_cnt++;
      tick();
    end
    #1;
    total_cnt++; if (p0_cmd_ready_o !== 1'b1 || p1_cmd_ready_o !== 1'b0)
      $display("FAIL lock_expire got p0=%b p1=%b want p0=1 p1=0", p0_cmd_ready_o, p1_cmd_ready_o); else pass_cnt++;
    $display("lock: p1 ran 16 accepts, p0 granted");
    tick();
    #1;
    total_cnt++; if (p1_cmd_ready_o !== 1'b1) $display("FAIL lock_regrant got %b want 1", p1_cmd_ready_o); else pass_cnt++;
    tick();
    // p1 holds the lock but stops requesting: p0 is locked out until lock drops.
    p1_cmd_trigger_i = 1'b0;
    #1;
    total_cnt++; if (p0_cmd_ready_o !== 1'b0) $display("FAIL lock_hold got %b want 0", p0_cmd_ready_o); else pass_cnt++;
    tick();
    p1_lock_i = 1'b0;
    #1;
    total_cnt++; if (p0_cmd_ready_o !== 1'b0) $display("FAIL lock_release_pending got %b want 0", p0_cmd_ready_o); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (p0_cmd_ready_o !== 1'b1) $display("FAIL lock_released got %b want 1", p0_cmd_ready_o); else pass_cnt++;
    $display("lock: idle owner released, p0 granted");
    tick();
    p0_cmd_trigger_i = 1'b0;
  endtask

  task automatic test_error();
    ctl_cmd_read_data_valid_i = 1'b1; ctl_cmd_read_data_i = 16'hDEAD;
    #1;
    total_cnt++; if (p0_cmd_read_data_valid_o !== 1'b0 || p1_cmd_read_data_valid_o !== 1'b0)
      $display("FAIL err_no_valid got v0=%b v1=%b want 0/0", p0_cmd_read_data_valid_o, p1_cmd_read_data_valid_o); else pass_cnt++;
    tick();
    ctl_cmd_read_data_valid_i = 1'b0;
    #1;
    total_cnt++; if (err_o !== 1'b1) $display("FAIL err_set got %b want 1", err_o); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (err_o !== 1'b1) $display("FAIL err_sticky got %b want 1", err_o); else pass_cnt++;
    // Issue a read, then reset: the tag is lost and a late return flags err.
    rst_ni = 1'b0;
    #1;
    total_cnt++; if (err_o !== 1'b0) $display("FAIL err_cleared got %b want 0", err_o); else pass_cnt++;
    tick();
    rst_ni = 1'b1;
    p0_cmd_trigger_i = 1'b1; p0_cmd_write_i = 1'b0; p0_cmd_addr_i = 23'h000700;
    #1;
    total_cnt++; if (p0_cmd_ready_o !== 1'b1) $display("FAIL err_read_issue got %b want 1", p0_cmd_ready_o); else pass_cnt++;
    tick();
    p0_cmd_trigger_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    ctl_cmd_read_data_valid_i = 1'b1; ctl_cmd_read_data_i = 16'hBEEF;
    #1;
    total_cnt++; if (p0_cmd_read_data_valid_o !== 1'b0) $display("FAIL reset_drops_tag got %b want 0", p0_cmd_read_data_valid_o); else pass_cnt++;
    tick();
    ctl_cmd_read_data_valid_i = 1'b0;
    #1;
    total_cnt++; if (err_o !== 1'b1) $display("FAIL err_after_reset got %b want 1", err_o); else pass_cnt++;
    $display("error: stray return flagged, sticky until reset");
  endtask

  initial begin
    rst_ni = 1'b0;
    p0_cmd_trigger_i = 1'b0; p0_cmd_write_i = 1'b1; p0_cmd_addr_i = '0; p0_cmd_write_data_i = '0; p0_lock_i = 1'b0;
    p1_cmd_trigger_i = 1'b0; p1_cmd_write_i = 1'b1; p1_cmd_addr_i = '0; p1_cmd_write_data_i = '0; p1_lock_i = 1'b0;
    ctl_cmd_ready_i = 1'b0; ctl_cmd_read_data_i = '0; ctl_cmd_read_data_valid_i = 1'b0;
    test_reset();
    test_contention();
    test_read_routing();
    test_fifo_full();
    test_lock();
    test_error();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-port arbiter sharing the single command port of `SDRAMController` between two requesters, for example a pixel writer and a readout engine. Selects one requester per accepted command: round-robin by default, with an optional bounded lock for back-to-back runs. Records the issuing port of every accepted read in an in-order tag FIFO and steers each returned read word to that port. Sits between the requesters and the controller; adds zero cycles of command or read-data latency.

## Interface
- `AddrWidth`, 23, command address width; matches the controller.
- `ReadFifoDepth`, 8, maximum number of reads in flight (power of 2, ≥2).
- `LockMax`, 16, maximum consecutive commands one port may issue while holding lock (≥1).

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_`  in  1  asynchronous, active-low reset.
- `pN_cmdReady`  out  1  port N (N∈{0,1}) command is accepted on this edge if `pN_cmdTrigger` is high.
- `pN_cmdTrigger`  in  1  port N requests a command.
- `pN_cmdWrite`  in  1  1=write, 0=read.
- `pN_cmdAddr`  in  AddrWidth  word address.
- `pN_cmdWriteData`  in  16  write data.
- `pN_lock`  in  1  port N requests to keep the grant for its next command.
- `pN_cmdReadData`  out  16  read data; the `ctl_cmdReadData` bus, shared.
- `pN_cmdReadDataValid`  out  1  read data belongs to port N this cycle.
- `ctl_cmdReady`  in  1  controller can accept a command.
- `ctl_cmdTrigger`, `ctl_cmdWrite`, `ctl_cmdAddr`, `ctl_cmdWriteData`  out  1/1/AddrWidth/16  muxed command to controller.
- `ctl_cmdReadData`  in  16; `ctl_cmdReadDataValid`  in  1  controller read return.
- `err`  out  1  sticky; read data arrived with no read outstanding.

## Operation
- Registered state: `prio` (port favoured on contention), `lockOwner`/`lockActive`, `lockCnt` (0..LockMax), tag FIFO (`ReadFifoDepth`×1 bit, read/write pointers, count 0..ReadFifoDepth), `err`.
- Eligibility: port N is eligible when `pN_cmdTrigger` is high and it is not (a read AND FIFO count==ReadFifoDepth). Writes are never blocked by the FIFO.
- Selection (combinational): if `lockActive`, only `lockOwner` may be selected. Otherwise, if a single port is eligible, select it. If both are eligible, select `prio`.
- `sel` drives `ctl_cmd*`. `ctl_cmdTrigger` = eligible(sel). `pN_cmdReady` = `ctl_cmdReady` AND sel==N AND eligible(N). A non-selected port's ready is 0.
- Accept = `ctl_cmdTrigger` AND `ctl_cmdReady`. On accept by port N:
  - `prio` ← other port.
  - If the command is a read, push N into the tag FIFO.
  - If `pN_lock` is high and `lockCnt`+1 < LockMax: `lockActive`←1, `lockOwner`←N, `lockCnt`←`lockCnt`+1. Otherwise `lockActive`←0, `lockCnt`←0.
- Lock release without accept: if `lockActive` and the owner's `pN_lock` is low, clear the lock on the next edge.
- Read return: `pN_cmdReadDataValid` = `ctl_cmdReadDataValid` AND count>0 AND head==N. Pop on every valid with count>0. If valid arrives with count==0, set `err` and push nothing.
- Push and pop in the same cycle: count is unchanged and both operations take effect. The full check uses the registered count, so a read is blocked at full even when a pop happens on the same edge.

## Timing
- Reset (rst_ low, async): `prio`=0, `lockActive`=0, `lockCnt`=0, FIFO empty, `err`=0. Outputs: all ready/valid/trigger = 0. Data and address outputs follow the mux: sel=0 gives p0 fields.
- Command path is combinational, 0-cycle latency: the requester sees ready in the same cycle the controller sees trigger.
- Read-data path is combinational, 0-cycle latency. Ordering is preserved per controller order.
- Reset mid-operation clears outstanding tags. Read data returned after reset sets `err` (the controller is reset with it).
- A port with trigger held high and no lock gets at least 1 of every 2 accepts under contention. With lock, the wait is at most LockMax accepts.

## Test plan
- Reset: rst_ low, both triggers high → all readies 0, `ctl_cmdTrigger`=0, `err`=0. After release with `ctl_cmdReady`=1 → p0 accepted first.
- Contention: both ports issue writes continuously, `ctl_cmdReady`=1 → accepts alternate p0,p1,p0,p1; controller sees the matching addresses.
- Read routing: p0 reads 0x000010, p1 reads 0x000020, p0 reads 0x000030. Controller returns 0xAAAA, 0xBBBB, 0xCCCC → valid on p0, p1, p0 respectively, with that data.
- FIFO full: issue 8 reads with no returns → 9th read ready=0 while a p1 write is still accepted. One return → read accepted the next cycle.
- Lock: p1 lock=1 with continuous writes, p0 also requesting, LockMax=16 → p1 gets 16 consecutive accepts, then p0 is granted.
- Error: `ctl_cmdReadDataValid`=1 with FIFO empty → no port valid, `err`=1 and stays 1 until reset.
